// File: rtl/crp16_cond_pkg.sv
// Shared definitions for the CRP16 condition unit: condition-code values,
// flag bit positions inside the packed {v,c,n,z} status word, and the evaluator.
package crp16_cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Every one of the 16 encodings yields a defined result, so no X can escape.
  function automatic logic cond_taken(input logic [3:0] sel, input logic [3:0] f);
    logic v, c, n, z;
    logic res;
    v = f[FLAG_V];
    c = f[FLAG_C];
    n = f[FLAG_N];
    z = f[FLAG_Z];
    res = 1'b0;
    case (sel)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/crp16_cond_eval.sv
// Purely combinational condition evaluator: (cond_sel, flags) -> taken.
// Kept standalone so the predicated-execute stage can reuse it.
module crp16_cond_eval
  import crp16_cond_pkg::*;
(
  input  logic [3:0] cond_sel_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = cond_taken(cond_sel_i, flags_i);
  end

endmodule

// File: rtl/crp16_cond_unit.sv
// CRP16 condition unit: ALU flag status register plus a one-deep,
// valid/ready-handshaked branch condition result register.
module crp16_cond_unit
  import crp16_cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         FORWARD     = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flag_we,
  input  logic       v_in,
  input  logic       c_in,
  input  logic       n_in,
  input  logic       z_in,
  input  logic       flag_load,
  input  logic [3:0] flag_data,
  output logic [3:0] flags_out,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] cond_sel,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_taken
);

  logic [3:0] flags_q, flags_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_taken_q, resp_taken_d;
  logic [3:0] eval_flags;
  logic       eval_taken;
  logic       accept;

  // Restore beats a live ALU update when both arrive together.
  always_comb begin
    flags_d = flags_q;
    if (flag_load) begin
      flags_d = flag_data;
    end else if (flag_we) begin
      flags_d = {v_in, c_in, n_in, z_in};
    end
  end

  generate
    if (FORWARD) begin : g_fwd
      assign eval_flags = flags_d;
    end else begin : g_reg
      assign eval_flags = flags_q;
    end
  endgenerate

  crp16_cond_eval u_eval (
    .cond_sel_i (cond_sel),
    .flags_i    (eval_flags),
    .taken_o    (eval_taken)
  );

  assign req_ready = ~resp_valid_q | resp_ready;
  assign accept    = req_valid & req_ready;

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_taken_d = resp_taken_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_taken_d = eval_taken;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags_q      <= RESET_FLAGS;
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      resp_valid_q <= resp_valid_d;
      resp_taken_q <= resp_taken_d;
    end
  end

  assign flags_out  = flags_q;
  assign resp_valid = resp_valid_q;
  assign resp_taken = resp_taken_q;

endmodule

// File: tb/tb_crp16_cond_unit.sv
// Self-checking bench for crp16_cond_unit: a forwarding and a non-forwarding
// instance run in lockstep against a behavioural flag/handshake model.
module tb_crp16_cond_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       flag_we;
  logic [3:0] alu;
  logic       flag_load;
  logic [3:0] flag_data;
  logic       req_valid;
  logic [3:0] cond_sel;
  logic       resp_ready;

  logic [3:0] flags_out, flags_out_n;
  logic       req_ready, req_ready_n;
  logic       resp_valid, resp_valid_n;
  logic       resp_taken, resp_taken_n;

  always #5 clock = ~clock;

  crp16_cond_unit #(.RESET_FLAGS(4'b0000), .FORWARD(1'b1)) dut (
    .clock(clock), .reset(reset), .flag_we(flag_we),
    .v_in(alu[3]), .c_in(alu[2]), .n_in(alu[1]), .z_in(alu[0]),
    .flag_load(flag_load), .flag_data(flag_data), .flags_out(flags_out),
    .req_valid(req_valid), .req_ready(req_ready), .cond_sel(cond_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_taken(resp_taken)
  );

  crp16_cond_unit #(.RESET_FLAGS(4'b0000), .FORWARD(1'b0)) dut_nf (
    .clock(clock), .reset(reset), .flag_we(flag_we),
    .v_in(alu[3]), .c_in(alu[2]), .n_in(alu[1]), .z_in(alu[0]),
    .flag_load(flag_load), .flag_data(flag_data), .flags_out(flags_out_n),
    .req_valid(req_valid), .req_ready(req_ready_n), .cond_sel(cond_sel),
    .resp_valid(resp_valid_n), .resp_ready(resp_ready), .resp_taken(resp_taken_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [3:0] flags_m;
  logic       vld_m, tk1_m, tk0_m;
  int         acc_cnt, done_cnt;

  // Conditions come in complementary pairs: the even code tests a base
  // predicate, the odd code is its negation.
  function automatic logic ref_cond(input logic [3:0] sel, input logic [3:0] f);
    logic v, c, n, z, base;
    v = f[3]; c = f[2]; n = f[1]; z = f[0];
    case (sel[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ sel[0];
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] a, input logic ld, input logic [3:0] d,
                       input logic rv, input logic [3:0] cs, input logic rr);
    flag_we = we; alu = a; flag_load = ld; flag_data = d;
    req_valid = rv; cond_sel = cs; resp_ready = rr;
  endtask

  task automatic model_reset();
    flags_m = 4'b0000; vld_m = 1'b0; tk1_m = 1'b0; tk0_m = 1'b0;
  endtask

  // One clock cycle with the currently driven inputs, checked against the model.
  task automatic cyc(input string tag);
    logic       rdy;
    logic [3:0] nf;
    #1;
    rdy = !vld_m || resp_ready;
    check({tag, " req_ready"}, {3'b0, req_ready}, {3'b0, rdy});
    check({tag, " req_ready_nf"}, {3'b0, req_ready_n}, {3'b0, rdy});
    if (resp_valid && resp_ready) done_cnt++;
    nf = flag_load ? flag_data : (flag_we ? alu : flags_m);
    if (req_valid && rdy) begin
      tk1_m = ref_cond(cond_sel, nf);
      tk0_m = ref_cond(cond_sel, flags_m);
      vld_m = 1'b1;
      acc_cnt++;
    end else if (resp_ready) begin
      vld_m = 1'b0;
    end
    flags_m = nf;
    @(posedge clock);
    #1;
    check({tag, " flags"}, flags_out, flags_m);
    check({tag, " flags_nf"}, flags_out_n, flags_m);
    check({tag, " valid"}, {3'b0, resp_valid}, {3'b0, vld_m});
    check({tag, " valid_nf"}, {3'b0, resp_valid_n}, {3'b0, vld_m});
    check({tag, " taken"}, {3'b0, resp_taken}, {3'b0, tk1_m});
    check({tag, " taken_nf"}, {3'b0, resp_taken_n}, {3'b0, tk0_m});
  endtask

  typedef struct {
    logic       we;
    logic [3:0] alu;
    logic       ld;
    logic [3:0] data;
    logic       rv;
    logic [3:0] cond;
    logic       rr;
    logic [3:0] e_flags;
    logic       e_valid;
    logic       e_taken;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // we   alu    ld  data   rv cond rr  e_flags e_v e_t
    tbl[0] = '{1'b1, 4'b0101, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'b0101, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 4'b0101, 1'b1, 1'b1}; // EQ
    tbl[2] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'h8, 1'b1, 4'b0101, 1'b1, 1'b0}; // HI
    tbl[3] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'h9, 1'b1, 4'b0101, 1'b1, 1'b1}; // LS
    tbl[4] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'hA, 1'b1, 4'b0101, 1'b1, 1'b1}; // GE
    tbl[5] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'hC, 1'b1, 4'b0101, 1'b1, 1'b0}; // GT
    tbl[6] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'b0101, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 4'b0001, 1'b1, 4'b1010, 1'b0, 4'h0, 1'b1, 4'b1010, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'hB, 1'b1, 4'b1010, 1'b1, 1'b0}; // LT
    tbl[9] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'b1010, 1'b0, 1'b0};

    acc_cnt = 0; done_cnt = 0;
    model_reset();
    drive(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset flags", flags_out, 4'b0000);
    check("reset valid", {3'b0, resp_valid}, 4'h0);
    check("reset taken", {3'b0, resp_taken}, 4'h0);
    reset = 1'b0;

    // Flag capture, per-cycle conditions, and load-over-write priority
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].we, tbl[i].alu, tbl[i].ld, tbl[i].data, tbl[i].rv, tbl[i].cond, tbl[i].rr);
      cyc($sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl_flags", i), flags_out, tbl[i].e_flags);
      check($sformatf("vec%0d tbl_valid", i), {3'b0, resp_valid}, {3'b0, tbl[i].e_valid});
      check($sformatf("vec%0d tbl_taken", i), {3'b0, resp_taken}, {3'b0, tbl[i].e_taken});
      check($sformatf("vec%0d tbl_taken_nf", i), {3'b0, resp_taken_n}, {3'b0, tbl[i].e_taken});
    end

    // Reset asserted while a response is stalled
    drive(0, 4'h0, 1, 4'b1111, 1, 4'hE, 0);
    cyc("prerst");
    drive(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    reset = 1'b1;
    #1;
    check("async rst valid", {3'b0, resp_valid}, 4'h0);
    check("async rst flags", flags_out, 4'b0000);
    check("async rst taken", {3'b0, resp_taken}, 4'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("post rst ready", {3'b0, req_ready}, 4'h1);

    // Forwarding: flag write and VS request in the same cycle (0x7FFF+1)
    drive(1, 4'b1010, 0, 4'h0, 1, 4'h6, 1);
    cyc("fwd");
    check("fwd taken", {3'b0, resp_taken}, 4'h1);
    check("nofwd taken", {3'b0, resp_taken_n}, 4'h0);
    drive(0, 4'h0, 0, 4'h0, 0, 4'h0, 1);
    cyc("fwd idle");

    // Backpressure with AL requests held valid
    acc_cnt = 0; done_cnt = 0;
    drive(0, 4'h0, 0, 4'h0, 1, 4'hE, 0);
    cyc("bp accept");
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("bp stall%0d", i));
      check($sformatf("bp ready%0d", i), {3'b0, req_ready}, 4'h0);
      check($sformatf("bp taken%0d", i), {3'b0, resp_taken}, 4'h1);
    end
    drive(0, 4'b1111, 0, 4'h0, 1, 4'hE, 1);
    cyc("bp release");
    drive(0, 4'h0, 0, 4'h0, 0, 4'h0, 1);
    cyc("bp drain");
    cyc("bp idle");
    check("bp accepts", acc_cnt[3:0], 4'd2);
    check("bp completed", done_cnt[3:0], 4'd2);

    // Sweep every condition against every registered flag value
    for (int f = 0; f < 16; f++) begin
      drive(0, 4'h0, 1, f[3:0], 0, 4'h0, 1);
      cyc($sformatf("sweep load %0d", f));
      for (int c = 0; c < 16; c++) begin
        drive(0, 4'h0, 0, 4'h0, 1, c[3:0], 1);
        cyc($sformatf("sweep f%0d c%0d", f, c));
        if (c == 14) check($sformatf("AL f%0d", f), {3'b0, resp_taken}, 4'h1);
        if (c == 15) check($sformatf("NV f%0d", f), {3'b0, resp_taken}, 4'h0);
      end
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 3) == 0, 4'($urandom), ($urandom % 6) == 0, 4'($urandom),
            ($urandom % 4) != 0, 4'($urandom), ($urandom % 3) != 0);
      cyc($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
